pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the fetch stage; successor to the plain PC register.
//  Holds the fetch address and selects the next PC: increment, branch, jump, return, exception vector or hold.
//  Adds a boot/run/halt state machine, a misaligned-target flag and an optional return-address stack (RAS).
//  Sits between the hazard/branch logic and instruction memory; PCResult drives the IM address.
// PARAMETERS
//  ADDR_W        32            PC width in bits
//  RESET_VECTOR  32'h00000000  PC loaded on Reset
//  EXC_VECTOR    32'h80000180  PC loaded on Exception
//  INC           4             byte increment per sequential fetch
//  RAS_DEPTH     4             RAS entries (power of 2, >=2); used only with PC_RAS_EN
// PORTS
//  Clk           in   1       clock, all state updates on posedge
//  Reset         in   1       synchronous, active-high
//  Stall         in   1       hold PC (hazard unit)
//  Halt          in   1       enter HALTED
//  Resume        in   1       leave HALTED
//  BranchTaken   in   1       redirect to BranchTarget
//  BranchTarget  in   ADDR_W  branch destination
//  Jump          in   1       redirect to JumpTarget
//  Link          in   1       qualifies Jump as call (jal); pushes RAS
//  JumpTarget    in   ADDR_W  jump destination
//  Return        in   1       jr $ra
//  ReturnTarget  in   ADDR_W  register-file $ra value
//  Exception     in   1       redirect to EXC_VECTOR
//  PCResult      out  ADDR_W  current fetch address
//  PCPlusInc     out  ADDR_W  PCResult+INC, combinational
//  PCValid       out  1       PCResult is a real fetch this cycle
//  Misaligned    out  1       registered; last redirect target had addr[1:0]!=0
//  RasEmpty      out  1       RAS holds no entries
// BEHAVIOUR
//  Reset: PCResult=RESET_VECTOR, state=BOOT, PCValid=0, Misaligned=0, RAS cleared, RasEmpty=1.
//  States: BOOT -> RUN after exactly 1 cycle (PC held). RUN -> HALTED when Halt and no redirect.
//   HALTED -> RUN when Resume; Exception in HALTED -> RUN at EXC_VECTOR. PCValid=1 only in RUN.
//  Next-PC priority in RUN (one cycle latency, new PC visible after posedge):
//   Exception > BranchTaken > Jump > Return > Halt/Stall (hold) > PCResult+INC.
//  Redirects override Stall; a redirect is never dropped. BOOT/HALTED ignore all but Reset/Exception/Resume.
//  Arithmetic modulo 2^ADDR_W; PC at max wraps to 0 with no flag.
//  Redirect targets have bits [1:0] forced to 0; Misaligned=1 for the following cycle only, else 0.
//  Jump and Return same cycle: Jump wins; Return ignored, no RAS pop.
//  Reset mid-stall or mid-halt: Reset wins, full reset state.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH circular stack. Jump&Link pushes PCResult+INC.
//   Return pops; target = popped entry, or ReturnTarget when RasEmpty.
//   Push when full overwrites oldest (count saturates). Push+pop impossible (Jump wins).
//   Exception leaves the RAS unchanged.
//  PC_RAS_EN undefined: no RAS storage; Return always uses ReturnTarget; RasEmpty tied 1.
// STRUCTURE
//  Shared package pc_pkg: state enum {BOOT,RUN,HALTED}, RESET_VECTOR/EXC_VECTOR defaults, ALIGN_MASK.
//  One sub-module: pc_ras (push/pop/count, circular pointer), instantiated only under PC_RAS_EN.
//  Next-PC mux and state machine live in pc_sequencer.
// TESTING
//  1 Reset, then release -> PCResult=0, PCValid=0 for 1 cycle; then 0,4,8,0xC.
//  2 Stall 3 cycles at 0x10 -> PC holds 0x10; BranchTaken=1, target 0x40, with Stall -> 0x40.
//  3 BranchTaken(0x100)+Jump(0x200)+Exception same cycle -> 0x80000180; without Exception -> 0x100.
//  4 JumpTarget 0x203 -> PC 0x200, Misaligned=1 one cycle; PC 0xFFFFFFFC +INC -> 0x0.
//  5 PC_RAS_EN: jal at 0x20 -> push 0x24; Return (ReturnTarget=0x999) -> 0x24; Return again -> 0x998.
//  6 Halt -> PCValid=0, PC frozen; Resume -> PC increments; Reset while halted -> 0, BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared sequencer state encoding, default vectors and alignment mask
package pc_pkg;

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   cnt;
    assign top   = mem[ptr - 1'b1];
    assign empty = cnt == '0;
    // entry storage needs no reset; occupancy tracks validity
    always_ff @(posedge Clk)
        if (push) mem[ptr] <= din;
    // pointer wraps, count saturates at DEPTH so overflow simply drops the oldest
    always_ff @(posedge Clk)
        if (Reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt == (PW+1)'(DEPTH) ? cnt : cnt + 1'b1;
        end else if (pop) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with next-PC mux and boot/run/halt FSM; PC_RAS_EN adds a return-address stack
import pc_pkg::*;
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEF),
    parameter int                INC          = 4,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              Resume,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic              Link,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Return,
    input  logic [ADDR_W-1:0] ReturnTarget,
    input  logic              Exception,
    output logic [ADDR_W-1:0] PCResult,
    output logic [ADDR_W-1:0] PCPlusInc,
    output logic              PCValid,
    output logic              Misaligned,
    output logic              RasEmpty
);
    state_t            state, nstate;
    logic              run, redir, push, pop;
    logic [ADDR_W-1:0] tgt, ret_tgt;
    assign run       = state == RUN;
    assign PCPlusInc = PCResult + ADDR_W'(INC);
`ifdef PC_RAS_EN
    logic [ADDR_W-1:0] ras_top;
    pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .Clk  (Clk),
        .Reset(Reset),
        .push (push),
        .pop  (pop),
        .din  (PCPlusInc),
        .top  (ras_top),
        .empty(RasEmpty)
    );
    assign ret_tgt = RasEmpty ? ReturnTarget : ras_top;
`else
    logic unused_ras;
    assign unused_ras = ^{push, pop};
    assign RasEmpty   = 1'b1;
    assign ret_tgt    = ReturnTarget;
`endif
    // redirect selection: Exception acts in any state, the rest only while running
    always_comb begin
        redir  = Exception | (run & (BranchTaken | Jump | Return));
        tgt    = Exception ? EXC_VECTOR : BranchTaken ? BranchTarget : Jump ? JumpTarget : ret_tgt;
        push   = run & ~Exception & ~BranchTaken & Jump & Link;
        pop    = run & ~Exception & ~BranchTaken & ~Jump & Return & ~RasEmpty;
        nstate = redir ? RUN : state == BOOT ? RUN : state == HALTED ? (Resume ? RUN : HALTED) : Halt ? HALTED : RUN;
    end
    // PC register, state and registered flags; a redirect overrides Stall and Halt
    always_ff @(posedge Clk)
        if (Reset) begin
            PCResult   <= RESET_VECTOR;
            state      <= BOOT;
            PCValid    <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            state      <= nstate;
            PCValid    <= nstate == RUN;
            Misaligned <= redir & |(tgt[1:0] & ALIGN_MASK);
            if (redir) PCResult <= {tgt[ADDR_W-1:2], tgt[1:0] & ~ALIGN_MASK};
            else if (run & ~Halt & ~Stall) PCResult <= PCPlusInc;
        end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer; expectations follow PC_RAS_EN when defined
module tb_pc_sequencer;
    logic        Clk = 0, Reset = 0, Stall = 0, Halt = 0, Resume = 0;
    logic        BranchTaken = 0, Jump = 0, Link = 0, Return = 0, Exception = 0;
    logic [31:0] BranchTarget = 0, JumpTarget = 0, ReturnTarget = 0;
    logic [31:0] PCResult, PCPlusInc;
    logic        PCValid, Misaligned, RasEmpty;
    int          passed = 0, total = 0;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Halt(Halt), .Resume(Resume),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .Link(Link), .JumpTarget(JumpTarget),
        .Return(Return), .ReturnTarget(ReturnTarget), .Exception(Exception),
        .PCResult(PCResult), .PCPlusInc(PCPlusInc), .PCValid(PCValid),
        .Misaligned(Misaligned), .RasEmpty(RasEmpty)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        Stall = 0; Halt = 0; Resume = 0; BranchTaken = 0; Jump = 0; Link = 0;
        Return = 0; Exception = 0;
    endtask

    task automatic test_reset();
        Reset = 1; Stall = 1;
        step();
        total++; if (PCResult !== 32'h0) $display("FAIL reset_pc got %h want 0", PCResult); else passed++;
        total++; if (PCValid !== 1'b0) $display("FAIL reset_valid got %b want 0", PCValid); else passed++;
        total++; if (Misaligned !== 1'b0) $display("FAIL reset_mis got %b want 0", Misaligned); else passed++;
        total++; if (RasEmpty !== 1'b1) $display("FAIL reset_rasempty got %b want 1", RasEmpty); else passed++;
        Reset = 0; Stall = 0;
        step();
        total++; if (PCResult !== 32'h0 || PCValid !== 1'b1) $display("FAIL boot_exit got %h/%b want 0/1", PCResult, PCValid); else passed++;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (PCResult !== 32'(4*i)) $display("FAIL seq_%0d got %h want %h", i, PCResult, 32'(4*i)); else passed++;
        end
    endtask

    task automatic test_stall();
        step();
        total++; if (PCResult !== 32'h10) $display("FAIL pre_stall got %h want 10", PCResult); else passed++;
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (PCResult !== 32'h10) $display("FAIL stall_%0d got %h want 10", i, PCResult); else passed++;
        end
        BranchTaken = 1; BranchTarget = 32'h40;
        step();
        total++; if (PCResult !== 32'h40) $display("FAIL stall_branch got %h want 40", PCResult); else passed++;
        total++; if (Misaligned !== 1'b0) $display("FAIL stall_branch_mis got %b want 0", Misaligned); else passed++;
        clr();
    endtask

    task automatic test_priority();
        BranchTaken = 1; BranchTarget = 32'h100; Jump = 1; JumpTarget = 32'h200; Exception = 1;
        step();
        total++; if (PCResult !== 32'h8000_0180) $display("FAIL prio_exc got %h want 80000180", PCResult); else passed++;
        Exception = 0;
        step();
        total++; if (PCResult !== 32'h100) $display("FAIL prio_branch got %h want 100", PCResult); else passed++;
        clr();
    endtask

    task automatic test_misalign_wrap();
        Jump = 1; JumpTarget = 32'h203;
        step();
        total++; if (PCResult !== 32'h200) $display("FAIL mis_pc got %h want 200", PCResult); else passed++;
        total++; if (Misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", Misaligned); else passed++;
        clr();
        step();
        total++; if (PCResult !== 32'h204 || Misaligned !== 1'b0) $display("FAIL mis_clear got %h/%b want 204/0", PCResult, Misaligned); else passed++;
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        step();
        clr();
        total++; if (PCPlusInc !== 32'h0) $display("FAIL wrap_inc got %h want 0", PCPlusInc); else passed++;
        step();
        total++; if (PCResult !== 32'h0) $display("FAIL wrap_pc got %h want 0", PCResult); else passed++;
    endtask

    task automatic test_return();
        Jump = 1; JumpTarget = 32'h20;
        step();
        total++; if (PCResult !== 32'h20) $display("FAIL jr_setup got %h want 20", PCResult); else passed++;
        Link = 1; JumpTarget = 32'h300;
        step();
        clr();
        total++; if (PCResult !== 32'h300) $display("FAIL jal_pc got %h want 300", PCResult); else passed++;
`ifdef PC_RAS_EN
        total++; if (RasEmpty !== 1'b0) $display("FAIL jal_rasempty got %b want 0", RasEmpty); else passed++;
`else
        total++; if (RasEmpty !== 1'b1) $display("FAIL jal_rasempty got %b want 1", RasEmpty); else passed++;
`endif
        Return = 1; ReturnTarget = 32'h999;
        step();
`ifdef PC_RAS_EN
        total++; if (PCResult !== 32'h24 || Misaligned !== 1'b0) $display("FAIL ret1 got %h/%b want 24/0", PCResult, Misaligned); else passed++;
`else
        total++; if (PCResult !== 32'h998 || Misaligned !== 1'b1) $display("FAIL ret1 got %h/%b want 998/1", PCResult, Misaligned); else passed++;
`endif
        step();
        total++; if (PCResult !== 32'h998 || Misaligned !== 1'b1) $display("FAIL ret2 got %h/%b want 998/1", PCResult, Misaligned); else passed++;
        total++; if (RasEmpty !== 1'b1) $display("FAIL ret2_rasempty got %b want 1", RasEmpty); else passed++;
        Jump = 1; JumpTarget = 32'h500;
        step();
        clr();
        total++; if (PCResult !== 32'h500) $display("FAIL jump_over_ret got %h want 500", PCResult); else passed++;
    endtask

    task automatic test_halt();
        Halt = 1;
        step();
        total++; if (PCResult !== 32'h500 || PCValid !== 1'b0) $display("FAIL halt got %h/%b want 500/0", PCResult, PCValid); else passed++;
        BranchTaken = 1; BranchTarget = 32'h700;
        step();
        total++; if (PCResult !== 32'h500 || PCValid !== 1'b0) $display("FAIL halt_ignore got %h/%b want 500/0", PCResult, PCValid); else passed++;
        clr(); Resume = 1;
        step();
        total++; if (PCResult !== 32'h500 || PCValid !== 1'b1) $display("FAIL resume got %h/%b want 500/1", PCResult, PCValid); else passed++;
        clr();
        step();
        total++; if (PCResult !== 32'h504) $display("FAIL resume_inc got %h want 504", PCResult); else passed++;
        Halt = 1;
        step();
        Reset = 1;
        step();
        total++; if (PCResult !== 32'h0 || PCValid !== 1'b0) $display("FAIL halt_reset got %h/%b want 0/0", PCResult, PCValid); else passed++;
        Reset = 0; clr();
        step();
        total++; if (PCResult !== 32'h0 || PCValid !== 1'b1) $display("FAIL post_reset got %h/%b want 0/1", PCResult, PCValid); else passed++;
        step();
        total++; if (PCResult !== 32'h4) $display("FAIL post_reset_inc got %h want 4", PCResult); else passed++;
        Halt = 1;
        step();
        clr(); Exception = 1;
        step();
        clr();
        total++; if (PCResult !== 32'h8000_0180 || PCValid !== 1'b1) $display("FAIL halt_exc got %h/%b want 80000180/1", PCResult, PCValid); else passed++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_misalign_wrap();
        test_return();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
